// File: rtl/ysyx_22040125_lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, access size
// codes and the size-to-byte-lane mask.
package ysyx_22040125_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        ERR   = 2'd3
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Byte lanes touched by an access of the given size, before offset shift.
    function automatic logic [7:0] size_byte_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22040125_lsu_if.sv
// Request/response channel between the execute stage (master) and the LSU (slave).
interface ysyx_22040125_lsu_if
    import ysyx_22040125_lsu_pkg::*;
#(
    parameter int XLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic            req_wen;
    logic [XLEN-1:0] req_addr;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/ysyx_22040125_lsu_align.sv
// Byte-lane logic: load extraction/extension, read-modify-write store merge
// and alignment check. Purely combinational.
module ysyx_22040125_lsu_align
    import ysyx_22040125_lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      offset,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    input  logic [XLEN-1:0] ram_rdata,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] store_data,
    output logic            misaligned
);

    logic [XLEN-1:0]   lane;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] w_s;
    logic [7:0]        byte_mask;
    logic [XLEN-1:0]   bit_mask;
    logic [XLEN-1:0]   wdata_sh;

    assign lane = ram_rdata >> {offset, 3'b000};
    assign b_s  = lane[7:0];
    assign h_s  = lane[15:0];
    assign w_s  = lane[31:0];

    always_comb begin
        load_data = lane;
        case (size)
            SZ_B:    load_data = is_unsigned ? XLEN'(lane[7:0])  : XLEN'(b_s);
            SZ_H:    load_data = is_unsigned ? XLEN'(lane[15:0]) : XLEN'(h_s);
            SZ_W:    load_data = is_unsigned ? XLEN'(lane[31:0]) : XLEN'(w_s);
            default: load_data = lane;
        endcase
    end

    // The RAM has no byte enables, so untouched lanes are carried over from the read.
    assign byte_mask = size_byte_mask(size) << offset;
    assign wdata_sh  = wdata << {offset, 3'b000};

    always_comb begin
        bit_mask = '0;
        for (int i = 0; i < 8; i++) begin
            bit_mask[8*i +: 8] = {8{byte_mask[i]}};
        end
    end

    assign store_data = (ram_rdata & ~bit_mask) | (wdata_sh & bit_mask);

    always_comb begin
        case (size)
            SZ_H:    misaligned = offset[0];
            SZ_W:    misaligned = |offset[1:0];
            SZ_D:    misaligned = |offset;
            default: misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/ysyx_22040125_lsu.sv
// Load/store unit in front of a word-wide RAM without byte mask: one request
// in flight, fixed two-cycle response, stores done as read-modify-write.
module ysyx_22040125_lsu
    import ysyx_22040125_lsu_pkg::*;
#(
    parameter int RAM_AW = 32,
    parameter int XLEN   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    ysyx_22040125_lsu_if.slave bus,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [XLEN-1:0]   ram_wdata,
    output logic              ram_wen,
    input  logic [XLEN-1:0]   ram_rdata
);

    lsu_state_e        state_q, state_d;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [2:0]        off_q;
    logic [RAM_AW-1:0] widx_q;
    logic [XLEN-1:0]   wdata_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [XLEN-1:0]   resp_rdata_q;

    logic              idle;
    logic              accept;
    logic [2:0]        al_off;
    logic [1:0]        al_size;
    logic              al_uns;
    logic [XLEN-1:0]   load_data;
    logic [XLEN-1:0]   store_data;
    logic              misaligned;
    logic              unused_addr_hi;

    assign idle          = (state_q == IDLE);
    assign accept        = bus.req_valid && idle;
    assign bus.req_ready = idle;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;

    // Words alias: address bits above the RAM index are dropped.
    assign unused_addr_hi = ^bus.req_addr[XLEN-1:RAM_AW+3];

    // In IDLE the aligner only judges the incoming request; afterwards it works on the latched one.
    assign al_off  = idle ? bus.req_addr[2:0]  : off_q;
    assign al_size = idle ? bus.req_size       : size_q;
    assign al_uns  = idle ? bus.req_unsigned   : uns_q;

    ysyx_22040125_lsu_align #(.XLEN(XLEN)) u_align (
        .offset      (al_off),
        .size        (al_size),
        .is_unsigned (al_uns),
        .ram_rdata   (ram_rdata),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .store_data  (store_data),
        .misaligned  (misaligned)
    );

    always_comb begin
        state_d   = state_q;
        ram_wen   = 1'b0;
        ram_wdata = '0;
        ram_addr  = widx_q;
        case (state_q)
            IDLE: begin
                ram_addr = bus.req_valid ? bus.req_addr[RAM_AW+2:3] : '0;
                if (bus.req_valid) begin
                    if (misaligned)       state_d = ERR;
                    else if (bus.req_wen) state_d = STORE;
                    else                  state_d = LOAD;
                end
            end
            STORE: begin
                ram_wen   = 1'b1;
                ram_wdata = store_data;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            size_q  <= '0;
            uns_q   <= 1'b0;
            off_q   <= '0;
            widx_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            off_q   <= bus.req_addr[2:0];
            widx_q  <= bus.req_addr[RAM_AW+2:3];
            wdata_q <= bus.req_wdata;
        end
    end

    // Response stage: every non-IDLE state emits exactly one pulse on its way back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= !idle;
            resp_err_q   <= (state_q == ERR);
            case (state_q)
                LOAD:        resp_rdata_q <= load_data;
                STORE, ERR:  resp_rdata_q <= '0;
                default:     resp_rdata_q <= resp_rdata_q;
            endcase
        end
    end

endmodule
